// File: rtl/mrsp_regbank_if.sv
// Bus bundle for mrsp_regbank: write/step controls plus the combinational read port.
// The master drives operations and read selects; the slave is the register bank.
interface mrsp_regbank_if #(
    parameter int WIDTH = 16,
    parameter int REGS  = 4
);
    localparam int SEL_W  = $clog2(REGS);
    localparam int BSEL_W = (WIDTH > 8) ? $clog2(WIDTH / 8) : 1;

    logic [SEL_W-1:0]  SEL;
    logic [BSEL_W-1:0] BYTE_SEL;
    logic [7:0]        D_IN;
    logic              STO;
    logic [WIDTH-1:0]  A_IN;
    logic              STO_A;
    logic              INC;
    logic              DEC;
    logic [SEL_W-1:0]  RD_SEL;
    logic [WIDTH-1:0]  HI_LO;
    logic [7:0]        BYTE_OUT;
    logic              WRAP;

    modport master (
        output SEL, BYTE_SEL, D_IN, STO, A_IN, STO_A, INC, DEC, RD_SEL,
        input  HI_LO, BYTE_OUT, WRAP
    );

    modport slave (
        input  SEL, BYTE_SEL, D_IN, STO, A_IN, STO_A, INC, DEC, RD_SEL,
        output HI_LO, BYTE_OUT, WRAP
    );
endinterface

// File: rtl/mrsp_regbank.sv
// Bank of REGS pointer registers with byte-lane writes, full loads and +/-STEP with WRAP flag.
// Define MRSP_REGBANK_SATURATE_EN to clamp INC/DEC at the range limits instead of wrapping.
module mrsp_regbank #(
    parameter int          WIDTH = 16,
    parameter int          REGS  = 4,
    parameter int unsigned STEP  = 1
) (
    input logic         CLK,
    input logic         RST,
    mrsp_regbank_if.slave bus
);
    localparam int LANES = WIDTH / 8;
    localparam logic [WIDTH:0] STEP_EXT = (WIDTH + 1)'(STEP);

    logic [WIDTH-1:0] regs_q [REGS];
    logic [WIDTH-1:0] regs_d [REGS];
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] sel_val;
    logic [WIDTH:0]   inc_sum;
    logic [WIDTH:0]   dec_diff;

    // One extra bit on each side of the adder exposes carry-out / borrow.
    assign sel_val  = regs_q[bus.SEL];
    assign inc_sum  = {1'b0, sel_val} + STEP_EXT;
    assign dec_diff = {1'b0, sel_val} - STEP_EXT;

    always_comb begin
        // NOTE: combinational logic uses blocking assignments, and every output gets a default first so no latch is inferred.
        regs_d = regs_q;
        wrap_d = 1'b0;
        if (bus.STO_A) begin
            regs_d[bus.SEL] = bus.A_IN;
        end else if (bus.STO) begin
            for (int l = 0; l < LANES; l++) begin
                if (int'(bus.BYTE_SEL) == l) regs_d[bus.SEL][l*8 +: 8] = bus.D_IN;
            end
        end else if (bus.INC && !bus.DEC) begin
            wrap_d = inc_sum[WIDTH];
`ifdef MRSP_REGBANK_SATURATE_EN
            regs_d[bus.SEL] = inc_sum[WIDTH] ? {WIDTH{1'b1}} : inc_sum[WIDTH-1:0];
`else
            regs_d[bus.SEL] = inc_sum[WIDTH-1:0];
`endif
        end else if (bus.DEC && !bus.INC) begin
            wrap_d = dec_diff[WIDTH];
`ifdef MRSP_REGBANK_SATURATE_EN
            regs_d[bus.SEL] = dec_diff[WIDTH] ? '0 : dec_diff[WIDTH-1:0];
`else
            regs_d[bus.SEL] = dec_diff[WIDTH-1:0];
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: this array is a handful of flops feeding the address mux, not a RAM, so clearing every entry is cheap and required.
            for (int r = 0; r < REGS; r++) regs_q[r] <= '0;
            wrap_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            wrap_q <= wrap_d;
        end
    end

    // Read port is straight from state: no bypass of same-cycle writes.
    always_comb begin
        bus.BYTE_OUT = 8'h00;
        for (int l = 0; l < LANES; l++) begin
            if (int'(bus.BYTE_SEL) == l) bus.BYTE_OUT = regs_q[bus.RD_SEL][l*8 +: 8];
        end
    end

    assign bus.HI_LO = regs_q[bus.RD_SEL];
    assign bus.WRAP  = wrap_q;
endmodule

// File: doc/mrsp_regbank.md
# mrsp_regbank

Parametrised bank of pointer/address registers for the MRSP datapath. It generalises the single 16-bit byte-writable register to REGS registers of WIDTH bits. Each register supports byte-lane writes, full-word loads and post-increment/decrement by STEP, with a registered wrap indication. It sits between the byte-wide data bus and the address bus, feeding stack/memory pointers to the address mux.

## Interface
Parameters:
- WIDTH, 16, register width in bits; multiple of 8, range 8..32
- REGS, 4, number of registers; power of two, 2..16
- STEP, 1, increment/decrement amount; 1..2^(WIDTH-1)

Ports:
- CLK  in  1  single clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- SEL  in  clog2(REGS)  register targeted by STO/STO_A/INC/DEC
- BYTE_SEL  in  max(1,clog2(WIDTH/8))  byte lane for STO (0 = bits 7:0)
- D_IN  in  8  byte write data
- STO  in  1  write D_IN into lane BYTE_SEL of register SEL
- A_IN  in  WIDTH  full-word load data
- STO_A  in  1  load A_IN into register SEL
- INC  in  1  register SEL += STEP
- DEC  in  1  register SEL -= STEP
- RD_SEL  in  clog2(REGS)  read register select
- HI_LO  out  WIDTH  full value of register RD_SEL
- BYTE_OUT  out  8  lane BYTE_SEL of register RD_SEL, zero-extended
- WRAP  out  1  registered pulse: the previous cycle's INC/DEC crossed the 0 / 2^WIDTH boundary

## Operation
- One operation per cycle, on register SEL only. Priority: RST > STO_A > STO > INC/DEC.
- STO_A: register SEL <= A_IN. Any concurrent STO, INC and DEC are ignored.
- STO: only lane BYTE_SEL is replaced by D_IN; other lanes hold. A BYTE_SEL beyond WIDTH/8-1 writes nothing.
- INC without DEC: register <= (register + STEP) mod 2^WIDTH.
- DEC without INC: register <= (register - STEP) mod 2^WIDTH.
- INC and DEC together: no change, and WRAP stays 0.
- WRAP is set to 1 for one cycle when an executed INC has carry-out or an executed DEC has borrow. It is 0 otherwise, including on any cycle where STO_A or STO won priority.
- Non-selected registers always hold their value.
- Read path is combinational from register state. HI_LO and BYTE_OUT follow RD_SEL and BYTE_SEL within the same cycle.
- There is no write-to-read bypass. A write becomes visible on the read port after the clock edge.

## Timing
- RST high at an edge: all registers <= 0 and WRAP <= 0. After that edge, HI_LO = 0 and BYTE_OUT = 0.
- Reset asserted in the same cycle as any operation: reset wins and the operation is discarded.
- Write/step latency is 1 cycle: the value is visible on HI_LO in the cycle after the edge.
- WRAP is asserted in the cycle after the wrapping edge, for exactly one cycle.
- Back-to-back operations on the same register every cycle are legal. Each operation uses the value produced by the previous edge.

## Configuration
- MRSP_REGBANK_SATURATE_EN defined:
  - INC clamps at 2^WIDTH-1 and DEC clamps at 0 instead of wrapping.
  - WRAP pulses when clamping occurred, i.e. the true result was out of range.
- Macro undefined: modular wrap as described in Operation.
- Port list and all other behaviour are identical in both builds.

## Test plan
Conditions for all scenarios: WIDTH=16, REGS=4, STEP=1 unless noted.
- Reset: load 0xBEEF into all four registers, then pulse RST with STO_A=1 held -> every RD_SEL reads HI_LO=0x0000, WRAP=0.
- Byte writes: SEL=2, STO with BYTE_SEL=1, D_IN=0x12, then BYTE_SEL=0, D_IN=0x34 -> register 2 = 0x1234. Registers 0, 1 and 3 unchanged. With RD_SEL=2, BYTE_SEL=1, BYTE_OUT=0x12.
- Priority: register 1 = 0x00FF, then one cycle with STO_A (A_IN=0xAAAA), STO (D_IN=0x55) and INC all high -> 0xAAAA. Next cycle, STO and INC together -> byte write only, no increment.
- Wrap (macro undefined): register 0 = 0xFFFF, INC -> 0x0000 with WRAP=1 for one cycle. DEC -> 0xFFFF with WRAP=1. INC+DEC together -> unchanged, WRAP=0.
- Saturate (MRSP_REGBANK_SATURATE_EN): 0xFFFF, INC -> stays 0xFFFF with WRAP=1. 0x0000, DEC -> stays 0x0000 with WRAP=1.
- Parameter sweep: WIDTH=32, REGS=8, STEP=4:
  - register 7 = 0xFFFFFFFE, INC -> 0x00000002 with WRAP=1.
  - BYTE_SEL=3, D_IN=0x80 -> 0x80000002.
